// File: rtl/tsal_pkg.sv
// TSAL validation build: shared constants and frame FSM state type.
// Imported by the ADC reader and the top level.
package tsal_pkg;

    localparam int ADC_BITS   = 12;
    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        CLK_HI,
        CLK_LO,
        TAIL
    } state_e;

endpackage

// File: rtl/spi_adc_reader.sv
// Serial ADC frame engine: cs/s_clk generation, MSB-first shift register,
// result register and one-cycle valid pulse at frame end.
module spi_adc_reader
    import tsal_pkg::*;
#(
    parameter int CLK_DIV = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                s_data,
    output logic                s_clk,
    output logic                cs,
    output logic [ADC_BITS-1:0] result,
    output logic                valid
);

    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BW   = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] CNT_END = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_END = BW'(FRAME_BITS - 1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [ADC_BITS-1:0]     result_q, result_d;
    logic                    valid_q, valid_d;
    logic                    cs_q, cs_d;
    logic                    sclk_q, sclk_d;
    logic                    half_done;

    assign half_done = (cnt_q == CNT_END);

    // Next-state: each phase lasts HALF cycles; sample on every s_clk rise
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        result_d = result_q;
        valid_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LEAD;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            LEAD: begin
                if (half_done) begin
                    state_d = CLK_HI;
                    cnt_d   = '0;
                    shift_d = {shift_q[FRAME_BITS-2:0], s_data};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLK_HI: begin
                if (half_done) begin
                    state_d = CLK_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLK_LO: begin
                if (half_done) begin
                    cnt_d = '0;
                    if (bit_q == BIT_END) begin
                        state_d = TAIL;
                    end else begin
                        state_d = CLK_HI;
                        bit_d   = bit_q + 1'b1;
                        shift_d = {shift_q[FRAME_BITS-2:0], s_data};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TAIL: begin
                if (half_done) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    result_d = shift_q[FRAME_BITS-LEAD_ZEROS-1:0];
                    valid_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        cs_d   = (state_d == IDLE);
        sclk_d = (state_d == CLK_HI);
    end

    // Frame registers; reset drops cs high and s_clk low immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
        end
    end

    assign s_clk  = sclk_q;
    assign cs     = cs_q;
    assign result = result_q;
    assign valid  = valid_q;

endmodule

// File: rtl/tsal_top.sv
// TSAL validation top: sample timer, hysteresis on the TS voltage code,
// and green-steady / red-flashing LED drive.
module tsal_top
    import tsal_pkg::*;
#(
    parameter int                  CLK_DIV       = 12,
    parameter int                  SAMPLE_PERIOD = 12000,
    parameter logic [ADC_BITS-1:0] THRESH_HI     = 12'd2048,
    parameter logic [ADC_BITS-1:0] THRESH_LO     = 12'd1843,
    parameter int                  BLINK_HALF    = 1500000
) (
    input  logic clk,
    input  logic rst_btn,
    input  logic s_data,
    output logic s_clk,
    output logic cs,
    output logic green_led,
    output logic red_led
);

    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int LW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [TW-1:0] TIMER_END = TW'(SAMPLE_PERIOD - 1);
    localparam logic [LW-1:0] BLINK_END = LW'(BLINK_HALF - 1);

    logic [TW-1:0]       timer_q, timer_d;
    logic                ts_active_q, ts_active_d;
    logic                green_q, green_d;
    logic                red_q, red_d;
    logic [LW-1:0]       blink_q, blink_d;
    logic [ADC_BITS-1:0] result;
    logic                valid;
    logic                start;

    assign start = (timer_q == '0);

    spi_adc_reader #(
        .CLK_DIV (CLK_DIV)
    ) u_adc (
        .clk    (clk),
        .rst_n  (rst_btn),
        .start  (start),
        .s_data (s_data),
        .s_clk  (s_clk),
        .cs     (cs),
        .result (result),
        .valid  (valid)
    );

    // Free-running sample timer, a frame is requested when it wraps to 0
    always_comb begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TIMER_END) begin
            timer_d = '0;
        end
    end

    // Hysteresis decision once per completed frame
    always_comb begin
        ts_active_d = ts_active_q;
        if (valid) begin
            if (result >= THRESH_HI) begin
                ts_active_d = 1'b1;
            end else if (result < THRESH_LO) begin
                ts_active_d = 1'b0;
            end
        end
    end

    // LED drive: green_q still high means this is the first active cycle
    always_comb begin
        green_d = 1'b1;
        red_d   = 1'b0;
        blink_d = '0;
        if (ts_active_q) begin
            green_d = 1'b0;
            if (green_q) begin
                red_d = 1'b1;
            end else if (blink_q == BLINK_END) begin
                red_d = ~red_q;
            end else begin
                red_d   = red_q;
                blink_d = blink_q + 1'b1;
            end
        end
    end

    // State registers for timer, decision and LEDs
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            timer_q     <= '0;
            ts_active_q <= 1'b0;
            green_q     <= 1'b1;
            red_q       <= 1'b0;
            blink_q     <= '0;
        end else begin
            timer_q     <= timer_d;
            ts_active_q <= ts_active_d;
            green_q     <= green_d;
            red_q       <= red_d;
            blink_q     <= blink_d;
        end
    end

    assign green_led = green_q;
    assign red_led   = red_q;

endmodule

// File: tb/tb_tsal_top.sv
// Directed bench for tsal_top: frame timing, ADC model, hysteresis,
// blink cadence and asynchronous reset mid-frame.
module tb_tsal_top;

    logic clk = 1'b0;
    logic rst_btn = 1'b0;
    logic s_data = 1'b0;
    logic s_clk;
    logic cs;
    logic green_led;
    logic red_led;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] adc_word = 16'h0000;
    int idx = 16;

    int cyc = 0;
    int low_cnt = 0, rises = 0;
    int last_low = 0, last_rises = 0;
    int last_fall = 0, last_period = 0;
    int frames = 0, bad_idle = 0, both_on = 0;
    logic cs_prev = 1'b1, sclk_prev = 1'b0;

    tsal_top #(
        .CLK_DIV       (4),
        .SAMPLE_PERIOD (200),
        .THRESH_HI     (12'd2048),
        .THRESH_LO     (12'd1843),
        .BLINK_HALF    (100)
    ) dut (
        .clk       (clk),
        .rst_btn   (rst_btn),
        .s_data    (s_data),
        .s_clk     (s_clk),
        .cs        (cs),
        .green_led (green_led),
        .red_led   (red_led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ADC model: first bit on cs fall, next bit on each s_clk fall
    always @(posedge cs or negedge cs or negedge s_clk) begin
        if (cs !== 1'b0) begin
            idx = 16;
            s_data = 1'b0;
        end else begin
            if (idx == 16) idx = 15;
            else if (idx > 0) idx--;
            s_data = adc_word[idx];
        end
    end

    // Frame monitor sampled on the inactive clock edge
    always @(negedge clk) begin
        if (cs === 1'b0) begin
            low_cnt++;
            if (s_clk === 1'b1 && sclk_prev === 1'b0) rises++;
        end
        if (cs === 1'b1 && cs_prev === 1'b0) begin
            last_low = low_cnt;
            last_rises = rises;
            low_cnt = 0;
            rises = 0;
            frames++;
        end
        if (cs === 1'b0 && cs_prev === 1'b1) begin
            last_period = cyc - last_fall;
            last_fall = cyc;
        end
        if (cs === 1'b1 && s_clk !== 1'b0) bad_idle++;
        if (green_led === 1'b1 && red_led === 1'b1) both_on++;
        cs_prev = cs;
        sclk_prev = s_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cs(input logic v);
        int n = 0;
        while (cs !== v && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (cs !== v) chk("wait_cs_timeout", 32'(cs), 32'(v));
    endtask

    task automatic wait_frame_end();
        wait_cs(1'b0);
        wait_cs(1'b1);
    endtask

    task automatic do_frame(input logic [15:0] w);
        wait_frame_end();
        adc_word = w;
        wait_frame_end();
        repeat (3) @(negedge clk);
    endtask

    task automatic measure_toggle(output int n);
        logic r0;
        r0 = red_led;
        n = 0;
        while (red_led === r0 && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int bad;
        int n;
        #50;
        chk("rst_cs", 32'(cs), 1);
        chk("rst_sclk", 32'(s_clk), 0);
        chk("rst_green", 32'(green_led), 1);
        chk("rst_red", 32'(red_led), 0);
        #50;
        rst_btn = 1'b1;
        @(posedge clk);
        #1;
        chk("first_cs_fall", 32'(cs), 0);

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (green_led !== 1'b1 || red_led !== 1'b0) bad++;
        end
        chk("zero_data_leds", 32'(bad), 0);
        chk("frame_count", 32'(frames), 5);
        chk("cs_low_len", 32'(last_low), 68);
        chk("sclk_rises", 32'(last_rises), 16);
        chk("frame_period", 32'(last_period), 200);

        wait_frame_end();
        adc_word = 16'h0FFF;
        wait_frame_end();
        repeat (2) @(negedge clk);
        chk("fff_red_on", 32'(red_led), 1);
        chk("fff_green_off", 32'(green_led), 0);
        measure_toggle(n);
        chk("blink_half_1", 32'(n), 100);
        chk("blink_red_0", 32'(red_led), 0);
        measure_toggle(n);
        chk("blink_half_2", 32'(n), 100);
        chk("blink_red_1", 32'(red_led), 1);

        do_frame(16'd0);
        chk("zero_green", 32'(green_led), 1);
        chk("zero_red", 32'(red_led), 0);
        do_frame(16'd2100);
        chk("c2100_green", 32'(green_led), 0);
        chk("c2100_red", 32'(red_led), 1);
        do_frame(16'd1900);
        chk("c1900_green", 32'(green_led), 0);
        do_frame(16'd1800);
        chk("c1800_green", 32'(green_led), 1);
        chk("c1800_red", 32'(red_led), 0);
        do_frame(16'd2047);
        chk("c2047_green", 32'(green_led), 1);
        do_frame(16'd2048);
        chk("c2048_green", 32'(green_led), 0);
        do_frame(16'd1843);
        chk("c1843_green", 32'(green_led), 0);
        do_frame(16'd1842);
        chk("c1842_green", 32'(green_led), 1);
        do_frame(16'hF7FF);
        chk("lead_ignored_green", 32'(green_led), 1);

        do_frame(16'h0FFF);
        chk("pre_rst_green", 32'(green_led), 0);
        wait_cs(1'b0);
        repeat (10) @(negedge clk);
        rst_btn = 1'b0;
        #1;
        chk("midrst_cs", 32'(cs), 1);
        chk("midrst_sclk", 32'(s_clk), 0);
        chk("midrst_green", 32'(green_led), 1);
        chk("midrst_red", 32'(red_led), 0);
        #29;
        rst_btn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cs_fall", 32'(cs), 0);
        wait_frame_end();
        repeat (2) @(negedge clk);
        chk("post_rst_low_len", 32'(last_low), 68);
        chk("post_rst_red", 32'(red_led), 1);
        chk("post_rst_green", 32'(green_led), 0);

        chk("idle_sclk_low", 32'(bad_idle), 0);
        chk("leds_exclusive", 32'(both_on), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
